vcache_req_arbiter: RTL and testbench
=====================================

Name: vcache_req_arbiter

Overview:
Round-robin arbiter that shares one vcache (bsg_cache packet interface) among num_req_p requesters.
- Forwards the granted request packet to the cache.
- Records the requester ID in an in-order tag FIFO and routes each cache response back to the requester at the FIFO head.
- Keeps per-requester grant counters for the profiling flow.
- Sits between tile/host-side request sources and a single vcache instance.

Parameters:
num_req_p, 4, number of requesters (>=2)
pkt_width_p, 74, width of bsg_cache_pkt_s
data_width_p, 32, cache response data width
max_out_p, 4, max outstanding (granted, not yet responded) requests; tag FIFO depth
ctr_width_p, 32, width of each per-requester grant counter

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
req_v_i  in  num_req_p  per-requester request valid
req_pkt_i  in  num_req_p*pkt_width_p  per-requester packets, requester i at [i*pkt_width_p +: pkt_width_p]
req_ready_o  out  num_req_p  one-hot: packet i accepted this cycle
cache_v_o  out  1  packet valid to cache
cache_pkt_o  out  pkt_width_p  granted packet
cache_ready_i  in  1  cache accepts packet
cache_v_i  in  1  cache response valid
cache_data_i  in  data_width_p  cache response data
cache_yumi_o  out  1  response consumed
resp_v_o  out  num_req_p  one-hot response valid to the owning requester
resp_data_o  out  data_width_p  response data, broadcast to all requesters
resp_yumi_i  in  num_req_p  requester consumes response
grant_count_o  out  num_req_p*ctr_width_p  per-requester accepted-request counters
outstanding_o  out  $clog2(max_out_p+1)  current tag FIFO occupancy

Behaviour:
- Reset (async, active-high): last_r = num_req_p-1, so requester 0 has highest priority first. Tag FIFO empty; outstanding_o=0; all grant counters 0. Outputs: req_ready_o=0, cache_v_o=0, cache_yumi_o=0, resp_v_o=0.
- Arbitration is combinational and same-cycle:
  - Candidate = first i with req_v_i[i]=1, scanning (last_r+1) mod N upward with wrap.
  - cache_v_o = any(req_v_i) & ~fifo_full. cache_pkt_o = req_pkt_i[candidate]; don't-care when cache_v_o=0.
  - Accept = cache_v_o & cache_ready_i. On accept: req_ready_o[candidate]=1, else req_ready_o=0.
  - Request handshake is valid/ready. Requester holds v and pkt until req_ready_o[i]=1.
- On accept, at the clock edge:
  - last_r <= candidate.
  - Push candidate ID into the tag FIFO.
  - grant_count[candidate] += 1, wrapping modulo 2^ctr_width_p.
  - last_r is not updated without an accept.
- Full FIFO: fifo_full = (occupancy==max_out_p). It blocks cache_v_o even if a pop happens in the same cycle (conservative, no bypass).
- Response path:
  - head = FIFO head ID.
  - resp_v_o[head] = cache_v_i & ~fifo_empty; all other bits 0.
  - resp_data_o = cache_data_i.
  - cache_yumi_o = cache_v_i & ~fifo_empty & resp_yumi_i[head]. This is also the FIFO pop.
  - resp_yumi_i bits other than head are ignored.
- Simultaneous push and pop (FIFO not full): occupancy unchanged; new ID goes to tail, head advances.
- cache_v_i with empty FIFO is a protocol error: simulation assertion fires; cache_yumi_o=0; no state change.
- Responses return strictly in request order; the arbiter does no reordering.
- Reset mid-operation: all outstanding IDs are discarded. The cache must be reset in the same window.
- Latency: zero-cycle request forwarding and zero-cycle response routing. Arbitration state changes only at clock edges.

Test Plan:
- Single requester: req_v_i=4'b0100, cache_ready_i=1 for 3 cycles -> req_ready_o=4'b0100 each cycle; grant_count[2]=3; outstanding_o=3; then 3 responses D0..D2 -> resp_v_o=4'b0100 with data in order; outstanding_o=0.
- Fairness: all four req_v_i held high, cache always ready, responses consumed immediately -> grant order 0,1,2,3,0,1,2,3; after 8 accepts each grant_count=2.
- Backpressure: cache_ready_i=0 for 5 cycles with req_v_i=4'b1010 -> cache_v_o=1, req_ready_o=0, last_r unchanged; ready rises -> requester 1 granted first (last_r=3 after reset).
- FIFO full: max_out_p=4, no responses, 4 accepts -> cache_v_o=0 while req_v_i!=0. Response arriving the same cycle as a new request -> no grant that cycle; grant occurs the next cycle.
- Response routing with stall: FIFO holds IDs 3,0; cache_v_i=1, resp_yumi_i[3]=0 for 2 cycles -> cache_yumi_o=0, data held; resp_yumi_i[3]=1 -> pop; next response goes to requester 0.
- Async reset mid-stream: assert reset_i between clock edges with outstanding_o=2 -> outputs go to reset values immediately; after release, requester 0 wins first arbitration.

Source files
------------

// File: rtl/vcache_req_arbiter.sv
// Round-robin arbiter sharing one vcache among num_req_p requesters.
// Ports: per-requester req/resp handshakes, one cache pkt/resp port,
// per-requester grant counters and current outstanding-request count.
// A tag FIFO of requester IDs routes in-order responses back to owners.
module vcache_req_arbiter #(
    parameter int num_req_p    = 4,
    parameter int pkt_width_p  = 74,
    parameter int data_width_p = 32,
    parameter int max_out_p    = 4,
    parameter int ctr_width_p  = 32,
    localparam int occ_w_lp    = $clog2(max_out_p + 1)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_req_p-1:0]             req_v_i,
    input  logic [num_req_p*pkt_width_p-1:0] req_pkt_i,
    output logic [num_req_p-1:0]             req_ready_o,
    output logic                             cache_v_o,
    output logic [pkt_width_p-1:0]           cache_pkt_o,
    input  logic                             cache_ready_i,
    input  logic                             cache_v_i,
    input  logic [data_width_p-1:0]          cache_data_i,
    output logic                             cache_yumi_o,
    output logic [num_req_p-1:0]             resp_v_o,
    output logic [data_width_p-1:0]          resp_data_o,
    input  logic [num_req_p-1:0]             resp_yumi_i,
    output logic [num_req_p*ctr_width_p-1:0] grant_count_o,
    output logic [occ_w_lp-1:0]              outstanding_o
);

    localparam int id_w_lp  = $clog2(num_req_p);
    localparam int ptr_w_lp = (max_out_p > 1) ? $clog2(max_out_p) : 1;

    logic [id_w_lp-1:0]     last_q, last_d;
    logic [id_w_lp-1:0]     tag_q [max_out_p];
    logic [id_w_lp-1:0]     tag_d [max_out_p];
    logic [ptr_w_lp-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ptr_w_lp-1:0]    rd_ptr_q, rd_ptr_d;
    logic [occ_w_lp-1:0]    occ_q, occ_d;
    logic [ctr_width_p-1:0] ctr_q [num_req_p];
    logic [ctr_width_p-1:0] ctr_d [num_req_p];

    logic [id_w_lp-1:0] cand;
    logic [id_w_lp-1:0] head;
    logic               found;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               resp_live;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(
        input logic [ptr_w_lp-1:0] p
    );
        if (p == ptr_w_lp'(max_out_p - 1)) return '0;
        return p + 1'b1;
    endfunction

    // Scan from the requester after the last winner, wrapping around.
    always_comb begin
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= num_req_p; k++) begin
            logic [id_w_lp-1:0] idx;
            idx = id_w_lp'((int'(last_q) + k) % num_req_p);
            if (!found && req_v_i[idx]) begin
                found = 1'b1;
                cand  = idx;
            end
        end
    end

    assign fifo_full  = (occ_q == occ_w_lp'(max_out_p));
    assign fifo_empty = (occ_q == '0);

    // Full blocks issue even if a pop is under way this cycle (no bypass).
    assign cache_v_o   = ~reset_i & found & ~fifo_full;
    assign cache_pkt_o = req_pkt_i[cand*pkt_width_p +: pkt_width_p];
    assign push        = cache_v_o & cache_ready_i;

    always_comb begin
        req_ready_o = '0;
        if (push) req_ready_o[cand] = 1'b1;
    end

    assign head         = tag_q[rd_ptr_q];
    assign resp_live    = ~reset_i & cache_v_i & ~fifo_empty;
    assign resp_data_o  = cache_data_i;
    assign cache_yumi_o = resp_live & resp_yumi_i[head];
    assign pop          = cache_yumi_o;

    always_comb begin
        resp_v_o = '0;
        if (resp_live) resp_v_o[head] = 1'b1;
    end

    always_comb begin
        last_d   = last_q;
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        ctr_d    = ctr_q;
        if (push) begin
            last_d        = cand;
            tag_d[wr_ptr_q] = cand;
            wr_ptr_d      = ptr_inc(wr_ptr_q);
            ctr_d[cand]   = ctr_q[cand] + 1'b1;
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_q   <= id_w_lp'(num_req_p - 1);
            tag_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ctr_q    <= '{default: '0};
        end else begin
            last_q   <= last_d;
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            ctr_q    <= ctr_d;
        end
    end

    for (genvar i = 0; i < num_req_p; i++) begin : g_cnt
        assign grant_count_o[i*ctr_width_p +: ctr_width_p] = ctr_q[i];
    end

    assign outstanding_o = occ_q;

    // A response with nothing outstanding means the cache is out of sync.
    resp_without_req_a: assert property (
        @(posedge clk_i) disable iff (reset_i) !(cache_v_i && fifo_empty)
    );

endmodule

// File: tb/tb_vcache_req_arbiter.sv
// Scoreboard bench for vcache_req_arbiter: stimulus pushes expected
// grants/responses into queues, a negedge monitor pops and compares.
module tb_vcache_req_arbiter;

    localparam int N  = 4;
    localparam int PW = 74;
    localparam int DW = 32;
    localparam int CW = 32;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic [N-1:0]    req_v_i;
    logic [N*PW-1:0] req_pkt_i;
    logic [N-1:0]    req_ready_o;
    logic            cache_v_o;
    logic [PW-1:0]   cache_pkt_o;
    logic            cache_ready_i;
    logic            cache_v_i;
    logic [DW-1:0]   cache_data_i;
    logic            cache_yumi_o;
    logic [N-1:0]    resp_v_o;
    logic [DW-1:0]   resp_data_o;
    logic [N-1:0]    resp_yumi_i;
    logic [N*CW-1:0] grant_count_o;
    logic [2:0]      outstanding_o;

    vcache_req_arbiter dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_v_i(req_v_i), .req_pkt_i(req_pkt_i),
        .req_ready_o(req_ready_o),
        .cache_v_o(cache_v_o), .cache_pkt_o(cache_pkt_o),
        .cache_ready_i(cache_ready_i),
        .cache_v_i(cache_v_i), .cache_data_i(cache_data_i),
        .cache_yumi_o(cache_yumi_o),
        .resp_v_o(resp_v_o), .resp_data_o(resp_data_o),
        .resp_yumi_i(resp_yumi_i),
        .grant_count_o(grant_count_o),
        .outstanding_o(outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    int          gq[$];
    int          rq_id[$];
    logic [31:0] rq_dat[$];

    function automatic logic [PW-1:0] pkt_of(input int i);
        logic [63:0] lo;
        lo = 64'(i) * 64'h0123_4567_89AB_CDEF + 64'h1111;
        return {2'(i), 8'hA5, lo};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] cnt(input int i);
        return grant_count_o[i*CW +: CW];
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        req_v_i       = '0;
        cache_ready_i = 1'b0;
        cache_v_i     = 1'b0;
        cache_data_i  = '0;
        resp_yumi_i   = '0;
    endtask

    task automatic do_reset();
        idle();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
    endtask

    task automatic exp_grant(input int id);
        gq.push_back(id);
    endtask

    task automatic resp(input int id, input logic [31:0] d,
                        input logic [N-1:0] yumi);
        cache_v_i    = 1'b1;
        cache_data_i = d;
        resp_yumi_i  = yumi;
        if (yumi[id]) begin
            rq_id.push_back(id);
            rq_dat.push_back(d);
        end
    endtask

    task automatic resp_off();
        cache_v_i   = 1'b0;
        resp_yumi_i = '0;
    endtask

    // Monitor: compare every accepted packet and consumed response.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!reset_i) begin
                if (req_ready_o != '0) begin
                    if (gq.size() == 0) begin
                        chk("unexpected_grant", 128'(req_ready_o), 128'(0));
                    end else begin
                        int id;
                        logic [N-1:0] oh;
                        id = gq.pop_front();
                        oh = N'(1) << id;
                        chk("grant_onehot", 128'(req_ready_o), 128'(oh));
                        chk("grant_pkt", 128'(cache_pkt_o),
                            128'(pkt_of(id)));
                    end
                end
                if (cache_yumi_o) begin
                    if (rq_id.size() == 0) begin
                        chk("unexpected_resp", 128'(resp_v_o), 128'(0));
                    end else begin
                        int id;
                        logic [N-1:0] oh;
                        logic [31:0] d;
                        id = rq_id.pop_front();
                        d  = rq_dat.pop_front();
                        oh = N'(1) << id;
                        chk("resp_route", 128'(resp_v_o), 128'(oh));
                        chk("resp_data", 128'(resp_data_o), 128'(d));
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) req_pkt_i[i*PW +: PW] = pkt_of(i);
        idle();
        reset_i = 1'b1;
        req_v_i = 4'b1111;
        cache_ready_i = 1'b1;
        #3;
        chk("rst_ready", 128'(req_ready_o), 128'(0));
        chk("rst_cache_v", 128'(cache_v_o), 128'(0));
        chk("rst_yumi", 128'(cache_yumi_o), 128'(0));
        chk("rst_resp_v", 128'(resp_v_o), 128'(0));
        chk("rst_outst", 128'(outstanding_o), 128'(0));
        chk("rst_counts", 128'(grant_count_o), 128'(0));
        step();
        idle();
        reset_i = 1'b0;

        // Single requester: three grants then three in-order responses.
        req_v_i = 4'b0100;
        cache_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_grant(2);
            step();
        end
        req_v_i = '0;
        #1;
        chk("single_cnt2", 128'(cnt(2)), 128'(3));
        chk("single_outst3", 128'(outstanding_o), 128'(3));
        for (int k = 0; k < 3; k++) begin
            resp(2, 32'hD000_0000 + 32'(k), 4'b0100);
            step();
        end
        resp_off();
        #1;
        chk("single_outst0", 128'(outstanding_o), 128'(0));

        // Fairness: all requesting, responses consumed right away.
        do_reset();
        req_v_i = 4'b1111;
        cache_ready_i = 1'b1;
        exp_grant(0);
        step();
        for (int c = 1; c < 8; c++) begin
            exp_grant(c % 4);
            resp((c - 1) % 4, 32'hF000_0000 + 32'(c), 4'b1111);
            step();
        end
        req_v_i = '0;
        resp(3, 32'hF000_0008, 4'b1111);
        step();
        resp_off();
        #1;
        for (int i = 0; i < N; i++) chk("fair_cnt", 128'(cnt(i)), 128'(2));
        chk("fair_outst0", 128'(outstanding_o), 128'(0));

        // Backpressure: cache stalls, then requester 1 wins first.
        do_reset();
        req_v_i = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_cache_v", 128'(cache_v_o), 128'(1));
            chk("bp_ready0", 128'(req_ready_o), 128'(0));
            step();
        end
        cache_ready_i = 1'b1;
        exp_grant(1);
        step();
        req_v_i = 4'b1000;
        exp_grant(3);
        step();
        req_v_i = '0;
        resp(1, 32'hB000_0001, 4'b0010);
        step();
        resp(3, 32'hB000_0003, 4'b1000);
        step();
        resp_off();
        #1;
        chk("bp_cnt1", 128'(cnt(1)), 128'(1));
        chk("bp_cnt3", 128'(cnt(3)), 128'(1));

        // FIFO full blocks issue, even in a cycle that pops.
        do_reset();
        req_v_i = 4'b0001;
        cache_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_grant(0);
            step();
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("full_cache_v", 128'(cache_v_o), 128'(0));
            chk("full_ready", 128'(req_ready_o), 128'(0));
            chk("full_outst", 128'(outstanding_o), 128'(4));
            step();
        end
        resp(0, 32'hE000_0000, 4'b0001);
        #1;
        chk("full_pop_no_v", 128'(cache_v_o), 128'(0));
        step();
        resp_off();
        exp_grant(0);
        step();
        req_v_i = '0;
        #1;
        chk("full_refill", 128'(outstanding_o), 128'(4));
        for (int k = 1; k <= 4; k++) begin
            resp(0, 32'hE000_0000 + 32'(k), 4'b0001);
            step();
        end
        resp_off();
        #1;
        chk("full_drain", 128'(outstanding_o), 128'(0));
        chk("full_cnt0", 128'(cnt(0)), 128'(5));

        // Response stall at head ID 3, then routing to requester 0.
        do_reset();
        cache_ready_i = 1'b1;
        req_v_i = 4'b1000;
        exp_grant(3);
        step();
        req_v_i = 4'b0001;
        exp_grant(0);
        step();
        req_v_i = '0;
        cache_v_i = 1'b1;
        cache_data_i = 32'hBEEF_0003;
        resp_yumi_i = 4'b0111;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("stall_resp_v", 128'(resp_v_o), 128'(4'b1000));
            chk("stall_yumi", 128'(cache_yumi_o), 128'(0));
            chk("stall_data", 128'(resp_data_o), 128'(32'hBEEF_0003));
            step();
        end
        resp(3, 32'hBEEF_0003, 4'b1000);
        step();
        resp(0, 32'hBEEF_0000, 4'b0001);
        #1;
        chk("route_next", 128'(resp_v_o), 128'(4'b0001));
        step();
        resp_off();
        #1;
        chk("route_outst0", 128'(outstanding_o), 128'(0));

        // Async reset between edges with two outstanding.
        do_reset();
        cache_ready_i = 1'b1;
        req_v_i = 4'b0100;
        exp_grant(2);
        step();
        exp_grant(2);
        step();
        req_v_i = '0;
        #1;
        chk("ar_outst2", 128'(outstanding_o), 128'(2));
        reset_i = 1'b1;
        req_v_i = 4'b1111;
        #1;
        chk("ar_cache_v", 128'(cache_v_o), 128'(0));
        chk("ar_ready", 128'(req_ready_o), 128'(0));
        chk("ar_outst", 128'(outstanding_o), 128'(0));
        chk("ar_cnt2", 128'(cnt(2)), 128'(0));
        step();
        reset_i = 1'b0;
        exp_grant(0);
        step();
        req_v_i = '0;
        #1;
        chk("ar_outst1", 128'(outstanding_o), 128'(1));
        resp(0, 32'hCAFE_0000, 4'b0001);
        step();
        resp_off();
        step();

        chk("grants_left", 128'(gq.size()), 128'(0));
        chk("resps_left", 128'(rq_id.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
